// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a classic five-stage MIPS-style pipeline.
// The instruction in IF/ID is decoded each cycle. Its control bits, register
// file operands and immediate are captured into the EX-side register on the
// next rising edge.
//
// A load-use hazard is detected here. It is reported upstream on stall_out,
// and a bubble is inserted into EX. A taken branch/jump in EX (flush) also
// inserts a bubble and takes priority over the hazard. A bubble clears only
// the four qualifying control bits. The data fields hold their previous
// values, so EX never sees glitching operands while it is idle.
//
// Ports
//   clock, reset          : single clock; synchronous active-high reset
//   if_id_instr/pc4/valid : instruction, PC+4 and valid flag from IF/ID
//   flush                 : discard the ID instruction (branch taken in EX)
//   rf_read_address_1/2   : combinational rs/rt fields to the register file
//   rf_data_1/2           : register file read data, captured at rising edge
//   stall_out             : combinational load-use hazard; upstream holds
//   ex_*                  : registered decode results presented to EX
//   stall_count           : saturating count of stall cycles
//   bubble_count          : saturating count of bubbles loaded (any cause)
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,

    input  logic [31:0]      if_id_instr,
    input  logic [31:0]      if_id_pc4,
    input  logic             if_id_valid,
    input  logic             flush,

    output logic [4:0]       rf_read_address_1,
    output logic [4:0]       rf_read_address_2,
    input  logic [31:0]      rf_data_1,
    input  logic [31:0]      rf_data_2,

    output logic             stall_out,

    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dest,
    output logic [4:0]       ex_shamt,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_funct,

    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
);

    // ------------------------------------------------------------------------
    // Opcodes recognised by the decoder. Any other value decodes as a NOP.
    // ------------------------------------------------------------------------
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0] FUNCT_JR = 6'h08;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Everything the EX stage sees, kept together so a bubble can clear the
    // control bits while leaving the data fields alone.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [5:0]  opcode;
        logic [5:0]  funct;
    } ex_t;

    ex_t              ex_q;
    ex_t              ex_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] bubble_count_q;
    logic [CNT_W-1:0] bubble_count_d;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    opcode_e     op;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_shamt;
    logic [5:0]  f_funct;
    logic [15:0] f_imm16;

    assign op      = opcode_e'(if_id_instr[31:26]);
    assign f_rs    = if_id_instr[25:21];
    assign f_rt    = if_id_instr[20:16];
    assign f_rd    = if_id_instr[15:11];
    assign f_shamt = if_id_instr[10:6];
    assign f_funct = if_id_instr[5:0];
    assign f_imm16 = if_id_instr[15:0];

    assign rf_read_address_1 = f_rs;
    assign rf_read_address_2 = f_rt;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic       dec_reg_write_raw;
    logic       dec_reg_write;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic [4:0] dec_dest;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, so no path leaves one unassigned and no latch is inferred.
        dec_reg_write_raw = 1'b0;
        dec_mem_read      = 1'b0;
        dec_mem_write     = 1'b0;
        dec_dest          = f_rt;

        case (op)
            OP_RTYPE: begin
                dec_dest          = f_rd;
                dec_reg_write_raw = (f_funct != FUNCT_JR);
            end
            OP_LW: begin
                dec_reg_write_raw = 1'b1;
                dec_mem_read      = 1'b1;
            end
            OP_SW: begin
                dec_mem_write     = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                dec_reg_write_raw = 1'b1;
            end
            OP_JAL: begin
                dec_dest          = REG_RA;
                dec_reg_write_raw = 1'b1;
            end
            // j, beq and bne write nothing. Unknown opcodes travel as NOPs.
            default: begin
            end
        endcase
    end

    // $0 is hard-wired, so a write to it is suppressed here once rather
    // than in every forwarding and writeback consumer downstream.
    assign dec_reg_write = dec_reg_write_raw & (dec_dest != 5'd0);

    // ------------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------------
    logic [31:0] dec_imm;

    always_comb begin
        dec_imm = {{16{f_imm16[15]}}, f_imm16};
        case (op)
            OP_ANDI, OP_ORI: dec_imm = {16'h0000, f_imm16};
            OP_LUI:          dec_imm = {f_imm16, 16'h0000};
            default:         dec_imm = {{16{f_imm16[15]}}, f_imm16};
        endcase
    end

    // ------------------------------------------------------------------------
    // Load-use hazard and bubble insertion
    //
    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time. Hold ID for one cycle and let a bubble into EX.
    // The next cycle, EX holds that bubble (ex_valid=0), so the hazard clears
    // by itself and the held instruction issues with fresh register data.
    // A flush discards the ID instruction, so it masks the hazard entirely.
    // ------------------------------------------------------------------------
    logic load_bubble;

    assign stall_out = ex_q.valid
                     & ex_q.mem_read
                     & (ex_q.dest != 5'd0)
                     & if_id_valid
                     & ~flush
                     & ((ex_q.dest == f_rs) | (ex_q.dest == f_rt));

    assign load_bubble = flush | stall_out | ~if_id_valid;

    always_comb begin
        ex_d = ex_q;
        if (load_bubble) begin
            ex_d.valid     = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.mem_write = 1'b0;
        end else begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = dec_reg_write;
            ex_d.mem_read  = dec_mem_read;
            ex_d.mem_write = dec_mem_write;
            ex_d.pc4       = if_id_pc4;
            ex_d.rs_data   = rf_data_1;
            ex_d.rt_data   = rf_data_2;
            ex_d.imm       = dec_imm;
            ex_d.rs        = f_rs;
            ex_d.rt        = f_rt;
            ex_d.dest      = dec_dest;
            ex_d.shamt     = f_shamt;
            ex_d.opcode    = if_id_instr[31:26];
            ex_d.funct     = f_funct;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating debug counters
    // ------------------------------------------------------------------------
    always_comb begin
        stall_count_d  = stall_count_q;
        bubble_count_d = bubble_count_q;
        if (stall_out && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
        if (load_bubble && (bubble_count_q != CNT_MAX)) begin
            bubble_count_d = bubble_count_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together from values sampled before the edge, whatever
        // order the statements appear in.
        if (reset) begin
            ex_q           <= '0;
            stall_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            stall_count_q  <= stall_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_pc4       = ex_q.pc4;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_dest      = ex_q.dest;
    assign ex_shamt     = ex_q.shamt;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct     = ex_q.funct;

    assign stall_count  = stall_count_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and bubble counters.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port if_id_instr, input, 32: instruction held in the IF/ID register.
REQ-005 SHALL have port if_id_pc4, input, 32: PC+4 of if_id_instr.
REQ-006 SHALL have port if_id_valid, input, 1: if_id_instr is a real instruction.
REQ-007 SHALL have port flush, input, 1: branch/jump taken in EX; the ID instruction is discarded.
REQ-008 SHALL have ports rf_read_address_1 and rf_read_address_2, output, 5 each: combinational instr[25:21] and instr[20:16] to the register file.
REQ-009 SHALL have ports rf_data_1 and rf_data_2, input, 32 each: register file read data, valid from the falling edge and captured at the next rising edge.
REQ-010 SHALL have port stall_out, output, 1: combinational load-use hazard; upstream holds PC and IF/ID.
REQ-011 SHALL have ports ex_valid, ex_reg_write and ex_mem_read, output, 1 each; ex_mem_write, output, 1.
REQ-012 SHALL have ports ex_pc4, ex_rs_data, ex_rt_data and ex_imm, output, 32 each.
REQ-013 SHALL have ports ex_rs, ex_rt, ex_dest and ex_shamt, output, 5 each; ex_opcode and ex_funct, output, 6 each.
REQ-014 SHALL have ports stall_count and bubble_count, output, CNT_W each: saturating debug counters.

Function
REQ-015 SHALL register all ex_* outputs on the rising clock edge; latency is one cycle from IF/ID to the ex_* outputs.
REQ-016 SHALL decode opcode 0x00 (R-type) to dest=rd and reg_write=1, except funct 0x08 (jr), which sets reg_write=0.
REQ-017 SHALL decode 0x23 (lw) to dest=rt, reg_write=1, mem_read=1; 0x2B (sw) to reg_write=0, mem_write=1.
REQ-018 SHALL decode 0x08, 0x09, 0x0A, 0x0C, 0x0D and 0x0F to dest=rt, reg_write=1.
REQ-019 SHALL decode 0x03 (jal) to dest=31, reg_write=1, and 0x02, 0x04 and 0x05 to reg_write=0.
REQ-020 SHALL treat any other opcode as a NOP (reg_write=0, mem_read=0, mem_write=0) with ex_valid still 1.
REQ-021 SHALL zero-extend imm[15:0] for opcodes 0x0C and 0x0D, place imm[15:0] in bits 31:16 for 0x0F, and sign-extend it otherwise.
REQ-022 SHALL force ex_reg_write=0 whenever ex_dest=0.
REQ-023 SHALL assert stall_out=1 when ex_valid=1, ex_mem_read=1, ex_dest!=0, if_id_valid=1, flush=0, and ex_dest equals instr[25:21] or instr[20:16].
REQ-024 SHALL load a bubble on a cycle with flush=1, stall_out=1 or if_id_valid=0: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write all 0.
REQ-025 SHALL leave the data fields unchanged during a bubble.
REQ-026 SHALL give flush priority over the hazard, so stall_out=0 whenever flush=1.
REQ-027 SHALL increment stall_count on each cycle with stall_out=1.
REQ-028 SHALL increment bubble_count on each cycle that loads a bubble for any cause.
REQ-029 SHALL saturate both counters at all-ones with no wrap.
REQ-030 SHALL, when a stall holds the instruction, resolve it on the next cycle: the bubble is now in EX, stall_out drops and the instruction issues with fresh rf_data.

Reset
REQ-031 SHALL, on reset=1 at a rising edge, clear every ex_* output and both counters to 0, overriding flush and stall.
REQ-032 SHALL keep stall_out=0 during the cycle after reset, since ex_valid=0.
REQ-033 SHALL resume normal capture on the first rising edge with reset=0.

Verification
REQ-034 SHALL cover reset: reset high for 2 cycles with a valid lw in IF/ID -> all ex_* outputs 0 and counters 0.
REQ-035 SHALL cover R-type decode: add $3,$1,$2 (0x00221820) with rf_data 5 and 7 -> next cycle ex_dest=3, ex_reg_write=1, ex_rs_data=5, ex_rt_data=7.
REQ-036 SHALL cover load-use: lw $4,8($29) followed by add $5,$4,$1 -> stall_out=1 for exactly 1 cycle, one bubble, then add issues, and stall_count=1, bubble_count=1.
REQ-037 SHALL cover immediates: ori imm 0x8000 -> ex_imm=0x00008000; addi imm 0x8000 -> ex_imm=0xFFFF8000; lui 0x1234 -> ex_imm=0x12340000.
REQ-038 SHALL cover flush over a hazard: flush=1 during a load-use hazard cycle -> stall_out=0, bubble loaded, stall_count unchanged.
REQ-039 SHALL cover saturation and zero destination: with CNT_W=2 and 5 bubbles -> bubble_count=3; addi $0,$0,1 -> ex_reg_write=0.
